// File: rtl/torus_eject_sink.sv
// ============================================================================
// Module  : torus_eject_sink
// Purpose : Torus NoC ejection sink. Accepts every flit and flags misroutes,
//           duplicates, out-of-range sequence numbers and late packets.
//           Returns one credit per flit and raises done after a quiet drain
//           window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module torus_eject_sink #(
   parameter int X_W       = 2,
   parameter int Y_W       = 2,
   parameter int D_W       = 28,
   parameter int N_PACKETS = 12,
   parameter int NODE_X    = 0,
   parameter int NODE_Y    = 0,
   parameter int DRAIN     = 8,
   parameter int X_MAX     = 1 << X_W,
   parameter int Y_MAX     = 1 << Y_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           out_v,
   input  logic [D_W-1:0] out,
   input  logic           gen_done,
   output logic           credit_out,
   output logic           done,
   output logic [15:0]    rx_count,
   output logic [3:0]     err_flags,
   output logic [D_W-1:0] err_pkt
);

   localparam int SEQ_W = D_W - 2*X_W - 2*Y_W;
   localparam int BM_N  = X_MAX * Y_MAX * N_PACKETS;
   localparam int IDX_W = (BM_N > 1) ? $clog2(BM_N) : 1;
   localparam int CNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   localparam logic [X_W-1:0]   C_NODE_X = X_W'(NODE_X);
   localparam logic [Y_W-1:0]   C_NODE_Y = Y_W'(NODE_Y);
   localparam logic [SEQ_W-1:0] C_NPK    = SEQ_W'(N_PACKETS);
   localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(DRAIN - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Input stage
   logic           v_q;
   logic [D_W-1:0] flit_q;
   logic           gen_done_q;

   // Datapath state
   logic             credit_q;
   logic [15:0]      rx_count_q;
   logic [3:0]       err_flags_q;
   logic [D_W-1:0]   err_pkt_q;
   logic [BM_N-1:0]  seen_q;

   // Drain FSM
   state_t           st_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   // Flit field decode
   logic [X_W-1:0]   w_dst_x;
   logic [Y_W-1:0]   w_dst_y;
   logic [X_W-1:0]   w_src_x;
   logic [Y_W-1:0]   w_src_y;
   logic [SEQ_W-1:0] w_seq;
   logic [IDX_W-1:0] w_idx;
   logic             w_seq_ok;
   logic             w_mis;
   logic             w_dup;
   logic             w_late;
   logic [3:0]       w_err;

   assign w_dst_x  = flit_q[D_W-1 -: X_W];
   assign w_dst_y  = flit_q[D_W-X_W-1 -: Y_W];
   assign w_src_x  = flit_q[D_W-X_W-Y_W-1 -: X_W];
   assign w_src_y  = flit_q[D_W-2*X_W-Y_W-1 -: Y_W];
   assign w_seq    = flit_q[SEQ_W-1:0];

   // Bitmap slot: one block of N_PACKETS bits per source node
   assign w_idx    = IDX_W'({w_src_y, w_src_x}) * IDX_W'(N_PACKETS) + IDX_W'(w_seq);
   assign w_seq_ok = (w_seq < C_NPK);
   assign w_mis    = (w_dst_x != C_NODE_X) || (w_dst_y != C_NODE_Y);
   // Only consult the bitmap when the index is legal
   assign w_dup    = w_seq_ok && seen_q[w_idx];
   assign w_late   = (st_q == ST_DONE);
   assign w_err    = v_q ? {w_late, ~w_seq_ok, w_dup, w_mis} : 4'b0000;

   // Register the ejection port and gen_done so all checks work on stable inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q        <= 1'b0;
         flit_q     <= '0;
         gen_done_q <= 1'b0;
      end else begin
         v_q        <= out_v;
         flit_q     <= out;
         gen_done_q <= gen_done;
      end
   end

   // Per-flit checking, counting, credit return and first-error capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q    <= 1'b0;
         rx_count_q  <= '0;
         err_flags_q <= '0;
         err_pkt_q   <= '0;
         seen_q      <= '0;
      end else begin
         credit_q    <= v_q;
         err_flags_q <= err_flags_q | w_err;
         if (v_q) begin
            if (rx_count_q != 16'hFFFF) begin
               rx_count_q <= rx_count_q + 16'd1;
            end
            if (w_seq_ok) begin
               seen_q[w_idx] <= 1'b1;
            end
         end
         if ((err_flags_q == 4'b0000) && (|w_err)) begin
            err_pkt_q <= flit_q;
         end
      end
   end

   // Drain tracking: done only after DRAIN quiet cycles with gen_done held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_RUN;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         case (st_q)
            ST_RUN: begin
               done_q <= 1'b0;
               if (gen_done_q) begin
                  st_q  <= ST_DRAIN;
                  cnt_q <= C_RELOAD;
               end
            end
            ST_DRAIN: begin
               if (!gen_done_q) begin
                  st_q <= ST_RUN;
               end else if (v_q) begin
                  cnt_q <= C_RELOAD;
               end else if (cnt_q == '0) begin
                  st_q   <= ST_DONE;
                  done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (!gen_done_q) begin
                  st_q   <= ST_RUN;
                  done_q <= 1'b0;
               end else if (v_q) begin
                  st_q   <= ST_DRAIN;
                  cnt_q  <= C_RELOAD;
                  done_q <= 1'b0;
               end
            end
            default: begin
               st_q   <= ST_RUN;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign credit_out = credit_q;
   assign done       = done_q;
   assign rx_count   = rx_count_q;
   assign err_flags  = err_flags_q;
   assign err_pkt    = err_pkt_q;

endmodule

`default_nettype wire

// File: tb/tb_torus_eject_sink.sv
// ============================================================================
// Module  : tb_torus_eject_sink
// Purpose : Directed self-checking bench for torus_eject_sink at node (1,2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_torus_eject_sink;

   localparam int D_W   = 28;
   localparam int DRAIN = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           out_v = 1'b0;
   logic [D_W-1:0] out = '0;
   logic           gen_done = 1'b0;
   logic           credit_out;
   logic           done;
   logic [15:0]    rx_count;
   logic [3:0]     err_flags;
   logic [D_W-1:0] err_pkt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   torus_eject_sink #(
      .X_W(2), .Y_W(2), .D_W(D_W), .N_PACKETS(12),
      .NODE_X(1), .NODE_Y(2), .DRAIN(DRAIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .out_v(out_v), .out(out), .gen_done(gen_done),
      .credit_out(credit_out), .done(done), .rx_count(rx_count),
      .err_flags(err_flags), .err_pkt(err_pkt)
   );

   function automatic logic [D_W-1:0] mk(input logic [1:0] dx, input logic [1:0] dy,
                                         input logic [1:0] sx, input logic [1:0] sy,
                                         input logic [19:0] seq);
      return {dx, dy, sx, sy, seq};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [D_W-1:0] f);
      out_v = 1'b1;
      out   = f;
      tick();
      out_v = 1'b0;
   endtask

   task automatic do_reset;
      rst_n    = 1'b0;
      out_v    = 1'b0;
      gen_done = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_done(output int n);
      n = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (done === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      logic [D_W-1:0] f;
      f        = mk(2'd1, 2'd2, 2'd0, 2'd0, 20'd0);
      rst_n    = 1'b0;
      gen_done = 1'b0;
      out_v    = 1'b1;
      out      = f;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({credit_out, done, rx_count, err_flags, err_pkt} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: got cr=%b dn=%b rx=%0d ef=%b ep=%h required all zero",
                     i, credit_out, done, rx_count, err_flags, err_pkt);
         end
      end
      rst_n = 1'b1;
      tick();
      out_v = 1'b0;
      n_checks++;
      if (rx_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_rel_lat: rx_count got %0d required 0", rx_count);
      end
      tick();
      n_checks++;
      if (rx_count !== 16'd1 || credit_out !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_flit: rx=%0d cr=%b required rx=1 cr=1", rx_count, credit_out);
      end
      tick();
      n_checks++;
      if (credit_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_credit_pulse: credit_out got %b required 0", credit_out);
      end
   endtask

   task automatic test_clean;
      int credits;
      int n;
      credits = 0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         out_v = 1'b1;
         out   = mk(2'd1, 2'd2, 2'd3, 2'd0, 20'(i));
         tick();
         if (credit_out === 1'b1) credits++;
         if (i >= 1) begin
            n_checks++;
            if (credit_out !== 1'b1) begin
               n_fail++;
               $display("FAIL clean_b2b_credit i=%0d: credit_out got %b required 1", i, credit_out);
            end
         end
      end
      out_v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (credit_out === 1'b1) credits++;
      end
      n_checks++;
      if (credits != 12) begin
         n_fail++;
         $display("FAIL clean_credits: got %0d pulses required 12", credits);
      end
      n_checks++;
      if (rx_count !== 16'd12 || err_flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL clean_count: rx=%0d ef=%b required rx=12 ef=0000", rx_count, err_flags);
      end
      gen_done = 1'b1;
      tick();
      wait_done(n);
      n_checks++;
      if (n != DRAIN + 1) begin
         n_fail++;
         $display("FAIL clean_done_latency: got %0d cycles required %0d", n, DRAIN + 1);
      end
      n_checks++;
      if (err_flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL clean_no_err: err_flags got %b required 0000", err_flags);
      end
   endtask

   task automatic test_misdup;
      logic [D_W-1:0] f1;
      logic [D_W-1:0] f2;
      f1 = mk(2'd2, 2'd2, 2'd0, 2'd0, 20'd0);
      f2 = mk(2'd1, 2'd2, 2'd0, 2'd0, 20'd5);
      do_reset();
      send(f1);
      send(f2);
      send(f2);
      tick();
      tick();
      n_checks++;
      if (err_flags !== 4'b0011 || err_pkt !== f1 || rx_count !== 16'd3) begin
         n_fail++;
         $display("FAIL misdup: ef=%b ep=%h rx=%0d required ef=0011 ep=%h rx=3",
                  err_flags, err_pkt, rx_count, f1);
      end
   endtask

   task automatic test_oor;
      logic [D_W-1:0] fa;
      fa = mk(2'd1, 2'd2, 2'd1, 2'd1, 20'd12);
      do_reset();
      send(fa);
      send(mk(2'd1, 2'd2, 2'd1, 2'd1, 20'hFFFFF));
      send(mk(2'd1, 2'd2, 2'd1, 2'd1, 20'd11));
      // seq 12 of src (1,1) would alias onto seq 0 of src (2,1)
      send(mk(2'd1, 2'd2, 2'd2, 2'd1, 20'd0));
      tick();
      tick();
      n_checks++;
      if (err_flags !== 4'b0100 || err_pkt !== fa || rx_count !== 16'd4) begin
         n_fail++;
         $display("FAIL oor: ef=%b ep=%h rx=%0d required ef=0100 ep=%h rx=4",
                  err_flags, err_pkt, rx_count, fa);
      end
      send(mk(2'd1, 2'd2, 2'd1, 2'd1, 20'd11));
      tick();
      n_checks++;
      if (err_flags !== 4'b0110 || err_pkt !== fa || rx_count !== 16'd5) begin
         n_fail++;
         $display("FAIL oor_then_dup: ef=%b ep=%h rx=%0d required ef=0110 ep=%h rx=5",
                  err_flags, err_pkt, rx_count, fa);
      end
   endtask

   task automatic test_drain_restart;
      int n;
      do_reset();
      gen_done = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      send(mk(2'd1, 2'd2, 2'd3, 2'd3, 20'd3));
      wait_done(n);
      n_checks++;
      if (n != DRAIN + 1) begin
         n_fail++;
         $display("FAIL drain_restart: done after %0d cycles required %0d", n, DRAIN + 1);
      end
      n_checks++;
      if (rx_count !== 16'd1 || err_flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL drain_restart_stat: rx=%0d ef=%b required rx=1 ef=0000", rx_count, err_flags);
      end
   endtask

   task automatic test_late;
      logic [D_W-1:0] f;
      int n;
      f = mk(2'd1, 2'd2, 2'd3, 2'd3, 20'd4);
      send(f);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL late_done_hold: done got %b required 1", done);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || err_flags !== 4'b1000 || err_pkt !== f || rx_count !== 16'd2) begin
         n_fail++;
         $display("FAIL late_flag: dn=%b ef=%b ep=%h rx=%0d required dn=0 ef=1000 ep=%h rx=2",
                  done, err_flags, err_pkt, rx_count, f);
      end
      wait_done(n);
      n_checks++;
      if (n != DRAIN) begin
         n_fail++;
         $display("FAIL late_redone: got %0d more cycles required %0d", n, DRAIN);
      end
   endtask

   task automatic test_gen_done_drop;
      gen_done = 1'b0;
      tick();
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL gen_done_drop: done got %b required 0", done);
      end
   endtask

   task automatic test_async_reset;
      gen_done = 1'b1;
      tick();
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (rx_count !== 16'd0 || err_flags !== 4'b0000 || done !== 1'b0 || err_pkt !== '0) begin
         n_fail++;
         $display("FAIL async_reset: rx=%0d ef=%b dn=%b ep=%h required all zero",
                  rx_count, err_flags, done, err_pkt);
      end
      tick();
      rst_n    = 1'b1;
      gen_done = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_misdup();
      test_oor();
      test_drain_restart();
      test_late();
      test_gen_done_drop();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
